// File: rtl/store_l2_pkg.sv
// Shared types, widths and the L2 memory-model entry points for the vector
// store path.
// Build macros:
//   STORE_L2_DPIC_READBACK_EN   - verify every store by reading it back.
// The memory model is a native byte-addressed model living in this package.
package store_l2_pkg;

  localparam int L2_VLEN = 2048;
  localparam int WORDS   = L2_VLEN / 32;
  localparam int BYTES   = L2_VLEN / 8;
  localparam int OFF_W   = $clog2(BYTES);

  typedef struct packed {
    logic [63:0]            paddr;
    logic [WORDS-1:0][31:0] data;
    logic [BYTES-1:0]       mask;
  } store_entry_t;

  typedef enum logic {
    IDLE,
    RETIRE
  } store_state_e;

  // Sparse byte memory plus a count of write calls, visible to the bench.
  logic [7:0]  pmem_mem [longint];
  int unsigned pmem_wr_cnt;

  function automatic void pmem_write(input longint paddr,
                                     input int data_bits [WORDS],
                                     input int mask_bits [WORDS]);
    pmem_wr_cnt++;
    for (int b = 0; b < BYTES; b++) begin
      if (((mask_bits[b/32] >> (b % 32)) & 1) != 0)
        pmem_mem[paddr + longint'(b)] = 8'(data_bits[b/4] >> (8 * (b % 4)));
    end
  endfunction

  function automatic void pmem_read(input longint paddr,
                                    output int data_bits [WORDS]);
    for (int w = 0; w < WORDS; w++) begin
      data_bits[w] = 0;
      for (int k = 0; k < 4; k++) begin
        longint a;
        a = paddr + longint'(4 * w + k);
        if (pmem_mem.exists(a))
          data_bits[w] = data_bits[w] | (int'(pmem_mem[a]) << (8 * k));
      end
    end
  endfunction

`ifdef STORE_L2_DPIC_READBACK_EN
  // True when any enabled byte read back differs from what was written.
  function automatic logic pmem_readback_bad(input longint paddr,
                                             input int data_bits [WORDS],
                                             input int mask_bits [WORDS]);
    int   rd [WORDS];
    logic bad;
    bad = 1'b0;
    pmem_read(paddr, rd);
    for (int b = 0; b < BYTES; b++) begin
      if ((((mask_bits[b/32] >> (b % 32)) & 1) != 0) &&
          (8'(rd[b/4] >> (8 * (b % 4))) != 8'(data_bits[b/4] >> (8 * (b % 4)))))
        bad = 1'b1;
    end
    return bad;
  endfunction
`endif

endpackage

// File: rtl/store_l2_fifo.sv
// DEPTH-entry circular buffer of store entries; push is ignored when full,
// pop is ignored when empty.
module store_l2_fifo
  import store_l2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  store_entry_t           din,
  input  logic                   pop,
  output store_entry_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  store_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // Entry storage write.
  // NOTE: the data array is deliberately not reset; only pointers and count
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; power-of-two DEPTH makes pointers wrap.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/store_l2_dpic.sv
// Vector store path into the L2 memory model: buffers masked VLEN-wide stores
// and retires one per cycle through pmem_write, acknowledging each retirement
// with a one-cycle wr_ack (wr_err flags misaligned or failed-readback entries).
// Build macro: STORE_L2_DPIC_READBACK_EN enables read-after-write checking.
module store_l2_dpic
  import store_l2_pkg::*;
#(
  parameter int VLEN  = L2_VLEN,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_paddr,
  input  logic [VLEN/32-1:0][31:0] req_data,
  input  logic [VLEN/8-1:0]       req_mask,
  input  logic                    drain_en,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    idle
);

  store_entry_t push_entry;
  store_entry_t head;
  store_state_e state_q;
  store_state_e state_d;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic         misaligned;
  int           data_bits [WORDS];
  int           mask_bits [WORDS];

  assign push_entry = '{paddr: req_paddr, data: req_data, mask: req_mask};
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign misaligned = (head.paddr[OFF_W-1:0] != '0);
  assign idle       = empty && !wr_ack;

  store_l2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Unpack the head entry into the int arrays the memory model expects;
  // the mask is packed 32 byte-enables per int, LSB = byte 0.
  // NOTE: every output gets a default before any conditional logic so the
  // combinational block can never infer a latch.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      data_bits[i] = int'(head.data[i]);
      mask_bits[i] = 0;
    end
    for (int i = 0; i < BYTES / 32; i++) begin
      mask_bits[i] = int'(head.mask[32*i +: 32]);
    end
  end

  // Retire FSM next state: retire whenever an entry is held and draining is allowed.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (!empty && drain_en) state_d = RETIRE;
      RETIRE:  state_d = (!empty && drain_en) ? RETIRE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop = (state_d == RETIRE);

  // Retire FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pop-edge memory write plus registered ack/err pulse for the popped entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= pop;
      wr_err <= pop && misaligned;
      if (pop && !misaligned && (head.mask != '0)) begin
        pmem_write(longint'(head.paddr), data_bits, mask_bits);
`ifdef STORE_L2_DPIC_READBACK_EN
        if (pmem_readback_bad(longint'(head.paddr), data_bits, mask_bits)) begin
          wr_err <= 1'b1;
          $error("store_l2_dpic: readback mismatch at paddr 0x%016h", head.paddr);
        end
`endif
      end
    end
  end

endmodule
